// File: rtl/led_chaser_seq.sv
// LED position sequencer: a prescaled or single-stepped ADVANCE walks a 3-bit
// index 0..7 either circularly (wrap) or back-and-forth (bounce).
module led_chaser_seq #(
    parameter int CLK_DIV = 5000000,
    parameter int DIV_W   = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       dir,
    input  logic       step_req,
    output logic [2:0] sel,
    output logic       tick,
    output logic       dir_out
);

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_step_d;
    logic [2:0]       r_sel;
    logic             r_tick;
    state_t           r_state;

    logic             w_div_wrap;
    logic             w_step_edge;
    logic             w_advance;
    state_t           w_state_nxt;
    logic [2:0]       w_sel_nxt;

    assign w_div_wrap  = (r_div == DIV_MAX);
    assign w_step_edge = step_req & ~r_step_d;
    // Step requests only count while paused; free-run owns the cadence otherwise.
    assign w_advance   = en ? w_div_wrap : w_step_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step_req;
            if (!en || w_div_wrap) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UP;
            r_sel   <= 3'd0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_tick  <= w_advance;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        if (w_advance) begin
            if (!mode) begin
                w_state_nxt = dir ? ST_DOWN : ST_UP;
                w_sel_nxt   = dir ? (r_sel - 3'd1) : (r_sel + 3'd1);
            end else if (r_state == ST_UP) begin
                // End points turn around immediately, with no dwell.
                if (r_sel == 3'd7) begin
                    w_state_nxt = ST_DOWN;
                    w_sel_nxt   = 3'd6;
                end else begin
                    w_sel_nxt   = r_sel + 3'd1;
                end
            end else begin
                if (r_sel == 3'd0) begin
                    w_state_nxt = ST_UP;
                    w_sel_nxt   = 3'd1;
                end else begin
                    w_sel_nxt   = r_sel - 3'd1;
                end
            end
        end
    end

    always_comb begin
        sel     = r_sel;
        tick    = r_tick;
        dir_out = r_state;
    end

endmodule

// File: tb/tb_led_chaser_seq.sv
// Bench for led_chaser_seq: directed vector table, bounce/step/reset sequences
// and randomized traffic against a position-track reference model.
module tb_led_chaser_seq;

  logic       clk = 1'b0;
  logic       rst, en, mode, dir, step_req;
  logic [2:0] sel;
  logic       tick, dir_out;

  logic       rst1, en1, z0;
  logic [2:0] sel1;
  logic       tick1, dir_out1;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  int m_sel, m_dir, m_run, m_tick;
  bit m_step_d;

  typedef struct {
    logic       rst, en, mode, dir, step;
    logic [2:0] sel;
    logic       tick, dout;
  } vec_t;
  vec_t vt[$];

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  led_chaser_seq #(.CLK_DIV(4), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .step_req(step_req),
    .sel(sel), .tick(tick), .dir_out(dir_out)
  );

  led_chaser_seq #(.CLK_DIV(1), .DIV_W(2)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(z0), .dir(z0), .step_req(z0),
    .sel(sel1), .tick(tick1), .dir_out(dir_out1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_dir = 0; m_run = 0; m_tick = 0; m_step_d = 0;
  endtask

  // Bounce is a walk around a 14-position ring; sel is the fold of ring position.
  task automatic model_edge();
    int adv, p;
    adv = 0;
    if (en) begin
      m_run++;
      if (m_run % 4 == 0) adv = 1;
    end else begin
      m_run = 0;
      if (step_req && !m_step_d) adv = 1;
    end
    m_step_d = step_req;
    if (adv != 0) begin
      if (!mode) begin
        m_dir = dir;
        m_sel = (m_sel + (dir ? 7 : 1)) % 8;
      end else begin
        p = m_dir ? (14 - m_sel) % 14 : m_sel;
        p = (p + 1) % 14;
        m_sel = (p < 8) ? p : 14 - p;
        m_dir = (p >= 8 || p == 0) ? 1 : 0;
      end
    end
    m_tick = adv;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("model_sel", sel, m_sel);
    chk("model_tick", tick, m_tick);
    chk("model_dir", dir_out, m_dir);
  endtask

  task automatic add(input logic r, input logic e, input logic m, input logic d,
                     input logic s, input logic [2:0] es, input logic et, input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.dir = d; v.step = s;
    v.sel = es; v.tick = et; v.dout = ed;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 0; mode = 0; dir = 0; step_req = 0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int cnt, last, gap;
    rst = 1; en = 0; mode = 0; dir = 0; step_req = 0;
    rst1 = 1; en1 = 0; z0 = 0;
    model_reset();

    // reset held while inputs toggle
    for (int i = 0; i < 8; i++) begin
      en = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1)); step_req = 1'($urandom_range(0, 1));
      cycle();
      chk("rst_sel", sel, 0);
      chk("rst_tick", tick, 0);
      chk("rst_dir", dir_out, 0);
    end

    //   rst en mo di st  sel  tk do
    add(1, 0, 0, 0, 0, 3'd0, 0, 0);
    add(0, 1, 0, 0, 0, 3'd0, 0, 0);
    add(0, 1, 0, 0, 0, 3'd0, 0, 0);
    add(0, 1, 0, 0, 0, 3'd0, 0, 0);
    add(0, 1, 0, 0, 0, 3'd1, 1, 0);
    add(0, 1, 0, 0, 0, 3'd1, 0, 0);
    add(0, 1, 0, 0, 0, 3'd1, 0, 0);
    add(0, 1, 0, 0, 0, 3'd1, 0, 0);
    add(0, 1, 0, 0, 0, 3'd2, 1, 0);
    add(0, 0, 0, 0, 1, 3'd3, 1, 0);
    add(0, 0, 0, 0, 1, 3'd3, 0, 0);
    add(0, 0, 0, 0, 1, 3'd3, 0, 0);
    add(0, 0, 0, 1, 0, 3'd3, 0, 0);
    add(0, 0, 0, 1, 1, 3'd2, 1, 1);
    add(0, 0, 0, 1, 0, 3'd2, 0, 1);
    add(0, 0, 0, 1, 1, 3'd1, 1, 1);
    add(0, 0, 0, 1, 0, 3'd1, 0, 1);
    add(0, 0, 0, 1, 1, 3'd0, 1, 1);
    add(0, 0, 0, 1, 0, 3'd0, 0, 1);
    add(0, 0, 0, 1, 1, 3'd7, 1, 1);
    add(0, 0, 1, 0, 0, 3'd7, 0, 1);
    add(0, 0, 1, 0, 1, 3'd6, 1, 1);
    add(0, 0, 1, 0, 0, 3'd6, 0, 1);
    foreach (vt[i]) begin
      rst = vt[i].rst; en = vt[i].en; mode = vt[i].mode;
      dir = vt[i].dir; step_req = vt[i].step;
      cycle();
      chk($sformatf("vec%0d_sel", i), sel, vt[i].sel);
      chk($sformatf("vec%0d_tick", i), tick, vt[i].tick);
      chk($sformatf("vec%0d_dir", i), dir_out, vt[i].dout);
    end
    rst = 0;

    // bounce from reset: 1..7, 6..0, 1 with direction flips at the ends
    do_reset();
    for (int s = 1; s <= 7; s++) exp_q.push_back({1'b0, 3'(s)});
    for (int s = 6; s >= 0; s--) exp_q.push_back({1'b1, 3'(s)});
    exp_q.push_back({1'b0, 3'd1});
    en = 1; mode = 1;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      cycle();
      if (tick) begin
        chk("bounce_sel", sel, exp_q[0][2:0]);
        chk("bounce_dir", dir_out, exp_q[0][3]);
        void'(exp_q.pop_front());
      end
    end
    chk("bounce_remaining", exp_q.size(), 0);

    // held step request gives one advance
    do_reset();
    cnt = 0;
    step_req = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (tick) cnt++;
    end
    chk("step_hold_ticks", cnt, 1);
    chk("step_hold_sel", sel, 1);

    // step pulses while running leave the 4-cycle cadence intact
    en = 1; cnt = 0; last = 0; gap = 0;
    for (int c = 1; c <= 40; c++) begin
      step_req = 1'($urandom_range(0, 1));
      cycle();
      if (tick) begin
        cnt++;
        chk("cadence_gap", c - last, 4);
        last = c;
      end
    end
    chk("cadence_ticks", cnt, 10);

    // randomized traffic
    step_req = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
      step_req = 1'($urandom_range(0, 1));
      cycle();
    end
    rst = 0;

    // asynchronous reset mid-cycle on the CLK_DIV=4 instance
    do_reset();
    en = 1; mode = 0; dir = 0; step_req = 0;
    for (int c = 0; c < 8; c++) cycle();
    chk("pre_async_sel", sel, 2);
    #2 rst = 1;
    #1;
    chk("async_sel", sel, 0);
    chk("async_tick", tick, 0);
    chk("async_dir", dir_out, 0);
    model_reset();
    en = 0;
    cycle();
    rst = 0;

    // CLK_DIV=1: advance on every edge, then asynchronous reset
    rst1 = 0; en1 = 1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      chk("div1_sel", sel1, k % 8);
      chk("div1_tick", tick1, 1);
    end
    #2 rst1 = 1;
    #1;
    chk("div1_async_sel", sel1, 0);
    chk("div1_async_tick", tick1, 0);
    chk("div1_async_dir", dir_out1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
